// File: rtl/rc_filter_pkg.sv
// Shared constants and helpers for the time-multiplexed RC IIR filter.
// Contents: mode encodings, coefficient-shift width, channel-index width helper.
// Imported by rc_iir_datapath and rc_iir_filter.
package rc_filter_pkg;

  // Filter response selected per channel.
  localparam logic MODE_LP = 1'b0;
  localparam logic MODE_HP = 1'b1;

  // Width of the per-channel coefficient exponent k (alpha = 2^-k).
  localparam int SHIFT_W = 3;

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int calc_cw(input int channels);
    if (channels <= 1) return 1;
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/rc_iir_datapath.sv
// Combinational first-order IIR update for one channel: S' = S + ((x<<FRAC) - S) >>> k.
// Latency: none (pure combinational, sits inside pipeline stage 2).
// Backpressure: none; ports s/x/k/mode in, s_next (new state) and y (signed result) out.
module rc_iir_datapath
  import rc_filter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic [WIDTH+FRAC-1:0] s,
  input  logic [WIDTH-1:0]      x,
  input  logic [SHIFT_W-1:0]    k,
  input  logic                  mode,
  output logic [WIDTH+FRAC-1:0] s_next,
  output logic [WIDTH:0]        y
);

  localparam int SW = WIDTH + FRAC;

  logic [SW-1:0]        x_ext;
  logic signed [SW:0]   diff;
  logic signed [SW:0]   diff_sh;
  logic [WIDTH-1:0]     lp;

  always_comb begin
    x_ext   = SW'(x) << FRAC;
    // One extra bit holds the sign of the error term; both operands are unsigned.
    diff    = $signed({1'b0, x_ext}) - $signed({1'b0, s});
    // Arithmetic shift rounds toward -inf, so S' never overshoots x<<FRAC
    // and the sum always fits back into SW unsigned bits.
    diff_sh = diff >>> k;
    s_next  = SW'($unsigned($signed({1'b0, s}) + diff_sh));
    lp      = s_next[SW-1:FRAC];
    if (mode == MODE_HP) begin
      // RC complement: what the low-pass path removed from the input.
      y = {1'b0, x} - {1'b0, lp};
    end else begin
      y = {1'b0, lp};
    end
  end

endmodule

// File: rtl/rc_iir_filter.sv
// Time-multiplexed first-order IIR (low/high-pass) over CHANNELS independent channels.
// Latency: 2 cycles from accept to out_valid, one sample per cycle in any channel order.
// Backpressure: in_ready = ena; no output stall, results appear as a one-cycle strobe.
// Ports: clk/rst_n; in_valid/in_ready/in_chan/in_data sample input;
//        cfg_we/cfg_chan/cfg_shift/cfg_mode/cfg_clear per-channel config;
//        out_valid/out_chan/out_data registered signed result.
module rc_iir_filter
  import rc_filter_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int CHANNELS  = 4,
  parameter  int FRAC      = 4,
  parameter  int SHIFT_RST = 2,
  localparam int CW        = calc_cw(CHANNELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CW-1:0]      in_chan,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               cfg_we,
  input  logic [CW-1:0]      cfg_chan,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_mode,
  input  logic               cfg_clear,
  output logic               out_valid,
  output logic [CW-1:0]      out_chan,
  output logic [WIDTH:0]     out_data
);

  localparam int SW = WIDTH + FRAC;

  // Per-channel state and configuration.
  logic [SW-1:0]      state_q [CHANNELS];
  logic [SHIFT_W-1:0] shift_q [CHANNELS];
  logic               mode_q  [CHANNELS];

  // Stage-1 registers (operands for the shared datapath).
  logic               s1_vld;
  logic [CW-1:0]      s1_chan;
  logic [WIDTH-1:0]   s1_x;
  logic [SW-1:0]      s1_s;
  logic [SHIFT_W-1:0] s1_k;
  logic               s1_mode;

  // Stage-1 next values after config bypass and forwarding.
  logic [SW-1:0]      rd_s;
  logic [SHIFT_W-1:0] rd_k;
  logic               rd_mode;

  logic               in_chan_ok;
  logic               cfg_chan_ok;
  logic               accept;
  logic               cfg_hit;

  // Stage-2 combinational results.
  logic [SW-1:0]      s_next;
  logic [WIDTH:0]     y;

  assign in_ready = ena;

  // Only channel codes below CHANNELS exist; with a power-of-two count every
  // code is valid and the range check disappears.
  generate
    if (CHANNELS == (1 << CW)) begin : g_full_range
      assign in_chan_ok  = 1'b1;
      assign cfg_chan_ok = 1'b1;
    end else begin : g_partial_range
      assign in_chan_ok  = (32'(in_chan)  < 32'(CHANNELS));
      assign cfg_chan_ok = (32'(cfg_chan) < 32'(CHANNELS));
    end
  endgenerate

  assign accept  = in_valid && ena && in_chan_ok;
  assign cfg_hit = cfg_we && cfg_chan_ok && (cfg_chan == in_chan);

  // Stage-1 operand selection. Priority, newest first: a config write in this
  // cycle (new k/mode, and a clear forces zero state), then the result stage 2
  // is producing for the same channel, then the stored arrays.
  always_comb begin
    rd_s    = '0;
    rd_k    = '0;
    rd_mode = MODE_LP;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_chan == CW'(c)) begin
        rd_s    = state_q[c];
        rd_k    = shift_q[c];
        rd_mode = mode_q[c];
      end
    end
    if (s1_vld && (s1_chan == in_chan)) begin
      rd_s = s_next;
    end
    if (cfg_hit) begin
      rd_k    = cfg_shift;
      rd_mode = cfg_mode;
      if (cfg_clear) begin
        rd_s = '0;
      end
    end
  end

  // Stage 1: capture the accepted sample with its resolved operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_chan <= '0;
      s1_x    <= '0;
      s1_s    <= '0;
      s1_k    <= '0;
      s1_mode <= MODE_LP;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_chan <= in_chan;
        s1_x    <= in_data;
        s1_s    <= rd_s;
        s1_k    <= rd_k;
        s1_mode <= rd_mode;
      end
    end
  end

  rc_iir_datapath #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_datapath (
    .s      (s1_s),
    .x      (s1_x),
    .k      (s1_k),
    .mode   (s1_mode),
    .s_next (s_next),
    .y      (y)
  );

  // Stage 2: register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_chan <= s1_chan;
        out_data <= y;
      end
    end
  end

  // Channel state and config. A clear landing while that channel's sample is
  // in stage 2 beats the write-back: the output keeps the pre-clear result,
  // the stored state ends at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= '0;
        shift_q[c] <= SHIFT_W'(SHIFT_RST);
        mode_q[c]  <= MODE_LP;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_we && cfg_chan_ok && (cfg_chan == CW'(c))) begin
          shift_q[c] <= cfg_shift;
          mode_q[c]  <= cfg_mode;
        end
        if (cfg_we && cfg_chan_ok && cfg_clear && (cfg_chan == CW'(c))) begin
          state_q[c] <= '0;
        end else if (s1_vld && (s1_chan == CW'(c))) begin
          state_q[c] <= s_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc_iir_filter.sv
// Directed bench for rc_iir_filter built with three channels, so code 3 is an
// out-of-range channel. Per-cycle vector table plus hand-written sequences for
// ena gaps and reset in the middle of the pipeline.
module tb_rc_iir_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_chan = '0;
  logic [7:0] in_data = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_chan = '0;
  logic [2:0] cfg_shift = '0;
  logic       cfg_mode = 1'b0;
  logic       cfg_clear = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_chan;
  logic [8:0] out_data;

  int checks = 0;
  int errors = 0;

  rc_iir_filter #(
    .WIDTH     (8),
    .CHANNELS  (3),
    .FRAC      (4),
    .SHIFT_RST (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chan   (in_chan),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_chan  (cfg_chan),
    .cfg_shift (cfg_shift),
    .cfg_mode  (cfg_mode),
    .cfg_clear (cfg_clear),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       iv;
    logic [1:0] ich;
    logic [7:0] ix;
    logic       cw;
    logic [1:0] cch;
    logic [2:0] csh;
    logic       cm;
    logic       cc;
    logic       ev;
    logic [1:0] ech;
    logic [8:0] ed;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(input logic e, input logic iv, input logic [1:0] ich,
                              input logic [7:0] ix, input logic cw, input logic [1:0] cch,
                              input logic [2:0] csh, input logic cm, input logic cc,
                              input logic ev, input logic [1:0] ech, input logic [8:0] ed);
    vec_t v;
    v.ena = e;  v.iv = iv;  v.ich = ich; v.ix = ix;
    v.cw = cw;  v.cch = cch; v.csh = csh; v.cm = cm; v.cc = cc;
    v.ev = ev;  v.ech = ech; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [1:0] ech,
                         input logic [8:0] ed);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      chk({tag, " out_chan"}, 32'(out_chan), 32'(ech));
      chk({tag, " out_data"}, 32'(out_data), 32'(ed));
    end
  endtask

  task automatic drive(input logic e, input logic iv, input logic [1:0] ich, input logic [7:0] ix,
                       input logic cw, input logic [1:0] cch, input logic [2:0] csh,
                       input logic cm, input logic cc);
    ena = e; in_valid = iv; in_chan = ich; in_data = ix;
    cfg_we = cw; cfg_chan = cch; cfg_shift = csh; cfg_mode = cm; cfg_clear = cc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Each row drives one cycle; the expectation is what the outputs show in
    // that same cycle (i.e. the result of the sample two rows earlier).
    //            ena iv ch  x    cw ch k  m  clr  ev ch data
    tbl[0]  = mk(1, 1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    tbl[2]  = mk(1, 1, 2, 0,   0, 0, 0, 0, 0,  1, 0, 0);
    tbl[3]  = mk(1, 1, 3, 99,  0, 0, 0, 0, 0,  1, 1, 0);   // channel 3 does not exist
    tbl[4]  = mk(1, 1, 0, 200, 1, 0, 1, 0, 0,  1, 2, 0);   // k=1 LP written with sample
    tbl[5]  = mk(1, 1, 0, 200, 0, 0, 0, 0, 0,  0, 0, 0);   // ch3 sample produced nothing
    tbl[6]  = mk(1, 1, 0, 200, 0, 0, 0, 0, 0,  1, 0, 100);
    tbl[7]  = mk(1, 1, 0, 200, 1, 0, 1, 1, 1,  1, 0, 150); // HP + clear with sample
    tbl[8]  = mk(1, 1, 0, 200, 0, 0, 0, 0, 0,  1, 0, 175);
    tbl[9]  = mk(1, 1, 0, 200, 0, 0, 0, 0, 0,  1, 0, 100);
    tbl[10] = mk(1, 1, 0, 77,  1, 0, 0, 0, 1,  1, 0, 50);  // k=0 LP
    tbl[11] = mk(1, 1, 1, 77,  1, 1, 0, 1, 0,  1, 0, 25);  // k=0 HP on ch1
    tbl[12] = mk(1, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 77);
    tbl[13] = mk(1, 1, 0, 200, 1, 0, 2, 0, 1,  1, 1, 0);
    tbl[14] = mk(1, 1, 1, 40,  1, 1, 2, 0, 1,  0, 0, 0);
    tbl[15] = mk(1, 1, 0, 200, 0, 0, 0, 0, 0,  1, 0, 50);
    tbl[16] = mk(1, 1, 1, 40,  0, 0, 0, 0, 0,  1, 1, 10);
    tbl[17] = mk(1, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 87);
    tbl[18] = mk(1, 0, 0, 0,   0, 0, 0, 0, 0,  1, 1, 17);
    tbl[19] = mk(0, 1, 2, 200, 0, 0, 0, 0, 0,  0, 0, 0);   // ena low: not accepted
    tbl[20] = mk(0, 1, 2, 200, 0, 0, 0, 0, 0,  0, 0, 0);
    tbl[21] = mk(1, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    tbl[22] = mk(1, 1, 0, 200, 1, 0, 1, 0, 0,  0, 0, 0);   // S=1400, k=1 -> 143
    tbl[23] = mk(1, 0, 0, 0,   1, 0, 1, 0, 1,  0, 0, 0);   // clear while in stage 2
    tbl[24] = mk(1, 1, 0, 200, 0, 0, 0, 0, 0,  1, 0, 143);
    tbl[25] = mk(1, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    tbl[26] = mk(1, 0, 0, 0,   0, 0, 0, 0, 0,  1, 0, 100); // started from cleared state

    // Reset phase: outputs must be zero while held in reset.
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_chan", 32'(out_chan), 32'd0);
      chk("reset out_data", 32'(out_data), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(tbl[i].ena, tbl[i].iv, tbl[i].ich, tbl[i].ix, tbl[i].cw, tbl[i].cch,
            tbl[i].csh, tbl[i].cm, tbl[i].cc);
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ena));
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ech, tbl[i].ed);
    end

    // ena gap of three cycles mid-stream. ch1 holds S=280 with k=2 LP -> 63.
    @(negedge clk); drive(1, 1, 1, 200, 0, 0, 0, 0, 0); #1;
    chk_out("gap0", 0, 0, 0);
    @(negedge clk); drive(0, 1, 2, 200, 0, 0, 0, 0, 0); #1;
    chk("gap1 in_ready", 32'(in_ready), 32'd0);
    chk_out("gap1", 0, 0, 0);
    @(negedge clk); drive(0, 1, 2, 200, 0, 0, 0, 0, 0); #1;
    chk("gap2 in_ready", 32'(in_ready), 32'd0);
    chk_out("gap2", 1, 1, 63);
    @(negedge clk); drive(0, 1, 2, 200, 0, 0, 0, 0, 0); #1;
    chk_out("gap3", 0, 0, 0);
    @(negedge clk); drive(1, 1, 2, 200, 0, 0, 0, 0, 0); #1;
    chk_out("gap4", 0, 0, 0);                              // nothing taken while ena low
    @(negedge clk); drive(1, 1, 0, 200, 0, 0, 0, 0, 0); #1;
    chk_out("gap5", 0, 0, 0);

    // Reset while the ch2 sample sits in stage 1 and a ch0 sample is presented.
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 0, 0, 0);
    chk("rst_mid out_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk_out($sformatf("rst_hold%0d", i), 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out($sformatf("post_rst%0d", i), 0, 0, 0);
      @(negedge clk);
    end

    // After reset every channel is back to k=2, LP, S=0: x=160 -> 40.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1, 1, 2'(i), 160, 0, 0, 0, 0, 0);
      else       drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (i >= 2) chk_out($sformatf("kreset ch%0d", i - 2), 1, 2'(i - 2), 40);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc_iir_filter.md
# rc_iir_filter

Parametrised, time-multiplexed first-order IIR filter: the digital successor to the passive RC filter tile. One shared datapath serves CHANNELS independent channels, each with its own state, a programmable coefficient alpha = 2^-k and a low-pass or high-pass (RC complement) mode. It sits behind the tile's pin wrapper, fed from ui_in/uio_in and driving uo_out/uio_out, and is also reusable as a core by other digital tiles.

## Interface
- WIDTH, 8: input sample width, unsigned.
- CHANNELS, 4: channel count, >=1; CW = max(1, clog2(CHANNELS)).
- FRAC, 4: extra fractional state bits; state width SW = WIDTH+FRAC.
- SHIFT_RST, 2: reset value of every channel's k.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- ena  in  1  accept enable; in_ready = ena.
- in_valid  in  1  sample present.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_chan  in  CW  channel of sample.
- in_data  in  WIDTH  sample x.
- cfg_we  in  1  config write strobe.
- cfg_chan  in  CW  channel to configure.
- cfg_shift  in  3  k, 0..7.
- cfg_mode  in  1  0 = low-pass, 1 = high-pass.
- cfg_clear  in  1  zero the channel state on this write.
- out_valid  out  1  one-cycle result strobe.
- out_chan  out  CW  channel of result.
- out_data  out  WIDTH+1  signed two's-complement result.

## Operation
- Per channel: state S (SW bits, unsigned), k, mode.
- Update on accepted x: D = {x, FRAC'b0} - S (SW+1 bits, signed); S' = S + (D >>> k) (arithmetic shift, truncating toward -inf). S' always lies between S and x<<FRAC; no overflow, no saturation needed.
- LP = S'[SW-1:FRAC] (truncate). Low-pass: out_data = {1'b0, LP}. High-pass: out_data = x - LP, signed WIDTH+1.
- k = 0: S' = x<<FRAC, so LP = x and HP = 0.
- cfg_we: writes k, mode; if cfg_clear, S = 0. Writes to in_chan >= CHANNELS and samples on such channels are ignored (no out_valid).
- Reset: all S = 0, k = SHIFT_RST, mode = low-pass, out_valid = 0, out_chan = 0, out_data = 0, pipeline empty.

## Timing
- Two-stage pipeline, full throughput (one sample per cycle, any channel order).
- Sample accepted in cycle T: stage 1 registers x, chan, S, k, mode at the end of T. Stage 2 computes S' in T+1, writes state and registers outputs at the end of T+1. out_valid is high in cycle T+2 only.
- Back-to-back same channel: stage-1 read forwards S' from stage 2, so the result equals sequential processing.
- Config write in cycle T with a sample on the same channel in T: the sample uses the new k/mode, and the cleared state (0) if cfg_clear is set.
- Clear in T+1 while a sample on that channel is in stage 2: output uses the pre-clear computation; the clear wins, so S = 0 after T+1.
- ena low: no accept; in-flight samples still complete.
- Async reset mid-operation: in-flight samples are dropped and no out_valid appears afterwards.

## Structure
- Package rc_filter_pkg: mode constants MODE_LP = 1'b0, MODE_HP = 1'b1; SHIFT_W = 3; function computing CW.
- Sub-module rc_iir_datapath: combinational S, x, k, mode -> S', out_data. Instantiated once in stage 2.
- Top holds the state/config register arrays, stage registers and the forwarding mux.

## Test plan
- Reset, then a sample on every channel with x = 0 -> out_data = 0 on each, 2 cycles after acceptance; check all outputs are 0 during reset.
- WIDTH 8, FRAC 4, k = 1, LP, ch0: x = 200, 200, 200 back-to-back -> out 100, 150, 175 on consecutive cycles (checks forwarding).
- Same stimulus in HP mode -> out 100, 50, 25; k = 0 with x = 77 -> LP 77, HP 0.
- Interleave ch0 x = 200 and ch1 x = 40 with k = 2 -> ch0 out 50, ch1 out 10, then ch0 87, ch1 17; channel states are independent.
- Clear ch0 in the cycle its sample sits in stage 2 -> that output is unaffected; next x = 200 with k = 1 -> out 100.
- Drop ena for 3 cycles mid-stream, then assert rst_n low mid-pipeline -> no accepts while ena is low; after reset no stray out_valid, and k = SHIFT_RST on all channels.
